trig_capture: RTL and testbench

TRIG_CAPTURE -- requirements
Module: trig_capture

---
 rtl/trig_capture_pkg.sv | 26 ++
 rtl/trig_capture_if.sv | 34 +++
 rtl/trig_capture.sv | 123 ++++++++++++
 tb/tb_trig_capture.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_capture_pkg.sv
// -----------------------------------------------------------------------------
// trig_capture_pkg
// Shared types and constants for the triggered waveform capture block:
// FSM state encoding, RAM address/data widths, the half-buffer depth and
// the sign-flip mask that turns two's-complement into offset binary.
// -----------------------------------------------------------------------------
package trig_capture_pkg;

   typedef enum logic [1:0] {
      ARMED  = 2'd0,
      ACTIVE = 2'd1,
      WAIT   = 2'd2
   } cap_state_e;

   localparam int          ADDR_W     = 9;
   localparam int          DATA_W     = 8;
   localparam int          HALF_DEPTH = 256;
   localparam int          IDX_W      = $clog2(HALF_DEPTH);
   localparam logic [7:0]  SIGN_FLIP  = 8'h80;

   // Upper byte of a signed sample mapped to unsigned offset binary.
   function automatic logic [DATA_W-1:0] to_offset_bin(input logic [DATA_W-1:0] msb);
      return msb ^ SIGN_FLIP;
   endfunction

endpackage

// File: rtl/trig_capture_if.sv
// -----------------------------------------------------------------------------
// trig_capture_if
// Sample stream in, display status in, sample RAM write port out.
//   new_sample_ready  : one-cycle strobe, new_sample_in valid
//   new_sample_in     : signed 16-bit audio sample
//   wave_display_idle : display not scanning, buffers may swap
//   write_address     : {buffer, index[7:0]}
//   write_enable      : one-cycle RAM write strobe
//   write_sample      : offset-binary 8-bit sample
//   read_index        : buffer half the display reads
// master = sample source / display side, slave = capture block.
// -----------------------------------------------------------------------------
interface trig_capture_if;
   import trig_capture_pkg::*;

   logic                new_sample_ready;
   logic [15:0]         new_sample_in;
   logic                wave_display_idle;
   logic [ADDR_W-1:0]   write_address;
   logic                write_enable;
   logic [DATA_W-1:0]   write_sample;
   logic                read_index;

   modport master (
      output new_sample_ready, new_sample_in, wave_display_idle,
      input  write_address, write_enable, write_sample, read_index
   );

   modport slave (
      input  new_sample_ready, new_sample_in, wave_display_idle,
      output write_address, write_enable, write_sample, read_index
   );

endinterface

// File: rtl/trig_capture.sv
// -----------------------------------------------------------------------------
// trig_capture
// Captures 256 audio samples per frame into one half of a double-buffered
// sample RAM, starting on a positive zero crossing (or forced after
// AUTO_TRIG_SAMPLES strobes without one). After a full capture it waits for
// the display to go idle, then swaps the buffer halves and re-arms.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : trig_capture_if.slave (sample in, RAM write port out)
// -----------------------------------------------------------------------------
module trig_capture
   import trig_capture_pkg::*;
#(
   parameter int AUTO_TRIG_SAMPLES = 1024
) (
   input  logic           clk,
   input  logic           reset,
   trig_capture_if.slave  bus
);

   localparam int                CNT_W     = $clog2(AUTO_TRIG_SAMPLES + 1);
   localparam logic [CNT_W-1:0]  AUTO_LAST = CNT_W'(AUTO_TRIG_SAMPLES - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(HALF_DEPTH - 1);

   cap_state_e          r_state;
   logic [IDX_W-1:0]    r_index;
   logic [CNT_W-1:0]    r_auto_cnt;
   logic                r_prev_neg;
   logic                r_read_index;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_data;

   cap_state_e          w_state_nxt;
   logic [IDX_W-1:0]    w_index_nxt;
   logic [CNT_W-1:0]    w_auto_nxt;
   logic [IDX_W-1:0]    w_wr_idx;
   logic                w_wr;
   logic                w_swap;
   logic                w_stb;
   logic                w_cross;
   logic                w_auto_hit;
   logic                w_unused;

   assign w_stb      = bus.new_sample_ready;
   assign w_cross    = w_stb & r_prev_neg & ~bus.new_sample_in[15];
   // The strobe that would bring the count to AUTO_TRIG_SAMPLES triggers.
   assign w_auto_hit = w_stb & (r_auto_cnt == AUTO_LAST);
   // Only the upper byte is stored; the low byte is intentionally dropped.
   assign w_unused   = ^bus.new_sample_in[7:0];

   always_comb begin
      w_state_nxt = r_state;
      w_index_nxt = r_index;
      w_auto_nxt  = r_auto_cnt;
      w_wr_idx    = r_index;
      w_wr        = 1'b0;
      w_swap      = 1'b0;
      case (r_state)
         ARMED: begin
            if (w_cross || w_auto_hit) begin
               w_wr        = 1'b1;
               w_wr_idx    = '0;
               w_index_nxt = IDX_W'(1);
               w_auto_nxt  = '0;
               w_state_nxt = ACTIVE;
            end else if (w_stb) begin
               w_auto_nxt  = r_auto_cnt + 1'b1;
            end
         end
         ACTIVE: begin
            if (w_stb) begin
               w_wr        = 1'b1;
               w_index_nxt = r_index + 1'b1;   // wraps to 0 after the last slot
               if (r_index == IDX_LAST) w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            // A strobe this cycle only refreshes prev_neg; no trigger check.
            if (bus.wave_display_idle) begin
               w_swap      = 1'b1;
               w_state_nxt = ARMED;
            end
         end
         default: w_state_nxt = ARMED;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ARMED;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_index      <= '0;
         r_auto_cnt   <= '0;
         r_prev_neg   <= 1'b0;
         r_read_index <= 1'b0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_data       <= '0;
      end else begin
         r_index    <= w_index_nxt;
         r_auto_cnt <= w_auto_nxt;
         r_we       <= w_wr;
         if (w_stb)  r_prev_neg   <= bus.new_sample_in[15];
         if (w_swap) r_read_index <= ~r_read_index;
         if (w_wr) begin
            // Capture always fills the half the display is not reading.
            r_addr <= {~r_read_index, w_wr_idx};
            r_data <= to_offset_bin(bus.new_sample_in[15:8]);
         end
      end
   end

   assign bus.write_enable  = r_we;
   assign bus.write_address = r_addr;
   assign bus.write_sample  = r_data;
   assign bus.read_index    = r_read_index;

endmodule

// File: tb/tb_trig_capture.sv
module tb_trig_capture;
   import trig_capture_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   trig_capture_if ifa();
   trig_capture_if ifb();

   trig_capture #(.AUTO_TRIG_SAMPLES(1024)) dut  (.clk(clk), .reset(rst_n), .bus(ifa));
   trig_capture #(.AUTO_TRIG_SAMPLES(8))    dut8 (.clk(clk), .reset(rst_n), .bus(ifb));

   assign ifb.new_sample_ready  = ifa.new_sample_ready;
   assign ifb.new_sample_in     = ifa.new_sample_in;
   assign ifb.wave_display_idle = ifa.wave_display_idle;

   typedef struct packed {
      logic [8:0] addr;
      logic [7:0] data;
   } wr_t;

   typedef struct {
      logic [15:0] s0;
      logic [15:0] s1;
      logic        exp;
      logic [7:0]  d;
   } vec_t;

   wr_t sbq[$];
   int  n_cmp = 0;
   int  n_bad = 0;
   int  wr_cnt = 0;
   int  run = 0;
   int  max_run = 0;
   int  wr8 = 0;
   logic [8:0] a8;
   logic [7:0] d8;

   function automatic logic [7:0] ob(input logic [15:0] s);
      return {~s[15], s[14:8]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [8:0] a, input logic [7:0] d);
      sbq.push_back(wr_t'{a, d});
   endtask

   // Called at posedge+1; returns at posedge+1.
   task automatic send(input logic [15:0] s, input int gap);
      ifa.new_sample_ready = 1'b1;
      ifa.new_sample_in    = s;
      @(posedge clk); #1;
      ifa.new_sample_ready = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      sbq.delete();
      run = 0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (sbq.size() == 0) break;
      end
      chk(name, sbq.size(), 0);
      sbq.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[7];
      int base;
      logic [15:0] v;

      ifa.new_sample_ready  = 1'b0;
      ifa.new_sample_in     = '0;
      ifa.wave_display_idle = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (ifa.write_enable === 1'b1) begin
               wr_cnt++;
               run++;
               if (run > max_run) max_run = run;
               if (sbq.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_write actual=addr %0h data %0h required=no write",
                           ifa.write_address, ifa.write_sample);
               end else begin
                  wr_t e;
                  e = sbq.pop_front();
                  chk("wr_addr", ifa.write_address, e.addr);
                  chk("wr_data", ifa.write_sample, e.data);
               end
            end else begin
               run = 0;
            end
            if (ifb.write_enable === 1'b1) begin
               wr8++;
               a8 = ifb.write_address;
               d8 = ifb.write_sample;
            end
         end
      join_none

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_we",   ifa.write_enable,  0);
      chk("rst_addr", ifa.write_address, 0);
      chk("rst_data", ifa.write_sample,  0);
      chk("rst_rdix", ifa.read_index,    0);
      rst_n = 1'b1;

      // Zero-crossing table: s0 then s1 straight after reset
      tbl[0] = '{16'hFFFF, 16'h0000, 1'b1, 8'h80};
      tbl[1] = '{16'hFFFF, 16'hFFFE, 1'b0, 8'h00};
      tbl[2] = '{16'h0001, 16'h0002, 1'b0, 8'h00};
      tbl[3] = '{16'h8000, 16'h7FFF, 1'b1, 8'hFF};
      tbl[4] = '{16'h0005, 16'hFFFB, 1'b0, 8'h00};
      tbl[5] = '{16'hFF00, 16'h0100, 1'b1, 8'h81};
      tbl[6] = '{16'h8000, 16'h8000, 1'b0, 8'h00};
      for (int k = 0; k < 7; k++) begin
         do_reset();
         base = wr_cnt;
         send(tbl[k].s0, 1);
         if (tbl[k].exp) push(9'h100, tbl[k].d);
         send(tbl[k].s1, 1);
         drain("vec_drain");
         chk("vec_wr_cnt", wr_cnt - base, {31'd0, tbl[k].exp});
      end

      // -100, -5, +7 then 255 more into upper half
      do_reset();
      send(16'hFF9C, 1);
      send(16'hFFFB, 1);
      push(9'h100, 8'h80);
      send(16'd7, 1);
      for (int i = 1; i < 256; i++) begin
         v = 16'(i * 100 - 12000);
         push(9'(256 + i), ob(v));
         send(v, 1);
      end
      drain("cap1_drain");
      chk("cap1_rdix", ifa.read_index, 0);

      // Strobes in WAIT with idle low: no writes
      base = wr_cnt;
      for (int i = 0; i < 100; i++) send(16'd500, 0);
      repeat (3) begin @(posedge clk); #1; end
      chk("wait_no_wr", wr_cnt - base, 0);
      chk("wait_rdix", ifa.read_index, 0);

      // Display idle -> swap one cycle later
      ifa.wave_display_idle = 1'b1;
      @(posedge clk); #1;
      chk("swap_rdix", ifa.read_index, 1);
      ifa.wave_display_idle = 1'b0;

      // Back-to-back capture into lower half; idle already high on WAIT entry
      max_run = 0;
      send(16'hFFFF, 0);
      push(9'h000, 8'h80);
      send(16'd2, 0);
      for (int i = 1; i < 256; i++) begin
         v = 16'(i * 128 - 16000);
         push(9'(i), ob(v));
         if (i == 255) ifa.wave_display_idle = 1'b1;
         send(v, 0);
      end
      chk("active_end_rdix", ifa.read_index, 1);
      @(posedge clk); #1;
      chk("early_idle_rdix", ifa.read_index, 0);
      ifa.wave_display_idle = 1'b0;
      drain("cap2_drain");
      chk("b2b_run", max_run, 256);

      // Auto trigger with AUTO_TRIG_SAMPLES = 8
      do_reset();
      wr8 = 0;
      base = wr_cnt;
      for (int i = 0; i < 7; i++) send(16'd1000, 1);
      chk("auto_pre", wr8, 0);
      send(16'd1000, 1);
      @(posedge clk); #1;
      chk("auto_cnt", wr8, 1);
      chk("auto_addr", a8, 9'h100);
      chk("auto_data", d8, 8'h83);
      chk("auto_1024_none", wr_cnt - base, 0);

      // Reset in the middle of a capture
      do_reset();
      send(16'hFFFD, 1);
      push(9'h100, 8'h80);
      send(16'd10, 1);
      for (int i = 1; i < 40; i++) begin
         v = 16'(i * 50);
         push(9'(256 + i), ob(v));
         send(v, 1);
      end
      drain("pre_rst_drain");
      send(16'd3000, 0);
      chk("we_before_rst", ifa.write_enable, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_we",   ifa.write_enable,  0);
      chk("mid_rst_addr", ifa.write_address, 0);
      chk("mid_rst_data", ifa.write_sample,  0);
      chk("mid_rst_rdix", ifa.read_index,    0);
      @(posedge clk); #1;
      send(16'hFFF9, 0);
      send(16'd9, 0);
      rst_n = 1'b1;
      base = wr_cnt;
      for (int i = 0; i < 3; i++) send(16'd20, 1);
      chk("post_rst_no_wr", wr_cnt - base, 0);
      send(16'hFFFE, 1);
      push(9'h100, 8'h80);
      send(16'd6, 1);
      push(9'h101, 8'h81);
      send(16'd300, 1);
      drain("post_rst_drain");
      chk("post_rst_wr", wr_cnt - base, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
